// File: rtl/regfile_write_arbiter_if.sv
// Handshake and register-file write bundle between two write requesters and the arbiter.
// Requester side drives valid/address/data; arbiter side drives readys and the write port.
interface regfile_write_arbiter_if;
  logic        a_valid_i;
  logic [4:0]  a_addr_i;
  logic [31:0] a_data_i;
  logic        a_ready_o;
  logic        b_valid_i;
  logic [4:0]  b_addr_i;
  logic [31:0] b_data_i;
  logic        b_ready_o;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic        b_starved_o;

  modport master (
    output a_valid_i, a_addr_i, a_data_i,
    output b_valid_i, b_addr_i, b_data_i,
    input  a_ready_o, b_ready_o,
    input  RegWrite_o, RDaddr_o, RDdata_o, b_starved_o
  );

  modport slave (
    input  a_valid_i, a_addr_i, a_data_i,
    input  b_valid_i, b_addr_i, b_data_i,
    output a_ready_o, b_ready_o,
    output RegWrite_o, RDaddr_o, RDdata_o, b_starved_o
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter: A (writeback) normally wins, B is forced
// through after STARVE_LIMIT held-off cycles. Single registered write port, latency 1.
//
// state   | meaning
// NORM    | A has priority; B only accepted when A is idle
// FORCE_B | B has priority after starving; A only accepted when B is idle
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter bit          DROP_R0      = 1'b1
) (
  input logic                    clk_i,
  input logic                    rst_i,
  regfile_write_arbiter_if.slave bus
);

  localparam logic [0:0] NORM    = 1'b0;
  localparam logic [0:0] FORCE_B = 1'b1;
  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

  logic [0:0]  state;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_inc;
  logic        a_ready;
  logic        b_ready;
  logic        a_acc;
  logic        b_acc;
  logic        issue;
  logic [4:0]  win_addr;
  logic [31:0] win_data;
  logic        write_q;
  logic [4:0]  addr_q;
  logic [31:0] data_q;

  // Readys depend only on state and valids so requesters never see a data-dependent ready.
  always_comb begin
    a_ready = 1'b1;
    b_ready = 1'b0;
    if (state == FORCE_B) begin
      b_ready = 1'b1;
      a_ready = !bus.b_valid_i;
    end else begin
      a_ready = 1'b1;
      b_ready = bus.b_valid_i && !bus.a_valid_i;
    end
  end

  always_comb begin
    a_acc    = bus.a_valid_i && a_ready;
    b_acc    = bus.b_valid_i && b_ready;
    win_addr = a_acc ? bus.a_addr_i : bus.b_addr_i;
    win_data = a_acc ? bus.a_data_i : bus.b_data_i;
    issue    = (a_acc || b_acc) && !(DROP_R0 && (win_addr == 5'd0));
    wait_inc = (wait_cnt == 4'd15) ? 4'd15 : wait_cnt + 4'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= NORM;
      wait_cnt <= 4'd0;
    end else if (state == FORCE_B) begin
      wait_cnt <= 4'd0;
      if (b_acc || !bus.b_valid_i) begin
        state <= NORM;
      end
    end else if (bus.b_valid_i && !b_acc) begin
      if (wait_inc == LIMIT) begin
        state    <= FORCE_B;
        wait_cnt <= 4'd0;
      end else begin
        wait_cnt <= wait_inc;
      end
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  // Dropped r0 writes leave the address/data registers untouched, like an idle cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_q <= 1'b0;
      addr_q  <= 5'd0;
      data_q  <= 32'd0;
    end else begin
      write_q <= issue;
      if (issue) begin
        addr_q <= win_addr;
        data_q <= win_data;
      end
    end
  end

  assign bus.a_ready_o   = a_ready;
  assign bus.b_ready_o   = b_ready;
  assign bus.RegWrite_o  = write_q;
  assign bus.RDaddr_o    = addr_q;
  assign bus.RDdata_o    = data_q;
  assign bus.b_starved_o = (state == FORCE_B);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: two instances (defaults, and STARVE_LIMIT=1/DROP_R0=0)
// share one stimulus; a priority/queue model is checked every cycle plus directed literals.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic [4:0]  a_addr = 5'd0;
  logic [31:0] a_data = 32'd0;
  logic        b_valid = 1'b0;
  logic [4:0]  b_addr = 5'd0;
  logic [31:0] b_data = 32'd0;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter_if if0 ();
  regfile_write_arbiter_if if1 ();

  assign if0.a_valid_i = a_valid;
  assign if0.a_addr_i  = a_addr;
  assign if0.a_data_i  = a_data;
  assign if0.b_valid_i = b_valid;
  assign if0.b_addr_i  = b_addr;
  assign if0.b_data_i  = b_data;
  assign if1.a_valid_i = a_valid;
  assign if1.a_addr_i  = a_addr;
  assign if1.a_data_i  = a_data;
  assign if1.b_valid_i = b_valid;
  assign if1.b_addr_i  = b_addr;
  assign if1.b_data_i  = b_data;

  regfile_write_arbiter dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
  regfile_write_arbiter #(.STARVE_LIMIT(1), .DROP_R0(1'b0)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Model: one instance per parameter set. Starvation tracked as a plain count of
  // consecutive held-off cycles; "favoured" says whose request always gets through.
  int          lim_m   [2] = '{3, 1};
  bit          drop_m  [2] = '{1'b1, 1'b0};
  int          wait_m  [2] = '{0, 0};
  bit          b_fav_m [2] = '{1'b0, 1'b0};
  bit          we_m    [2] = '{1'b0, 1'b0};
  logic [4:0]  addr_m  [2] = '{5'd0, 5'd0};
  logic [31:0] data_m  [2] = '{32'd0, 32'd0};
  logic [31:0] rf_m    [32];
  logic [31:0] rf_dut  [32];

  function automatic void ready_m(input int k, output bit ar, output bit br);
    if (b_fav_m[k]) begin
      br = 1'b1;
      ar = !b_valid;
    end else begin
      ar = 1'b1;
      br = b_valid && !a_valid;
    end
  endfunction

  task automatic step_m(input int k);
    bit ar, br, aa, ba;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    ready_m(k, ar, br);
    aa = a_valid && ar;
    ba = b_valid && br;
    we_m[k] = 1'b0;
    if (aa || ba) begin
      w_addr = aa ? a_addr : b_addr;
      w_data = aa ? a_data : b_data;
      if (!(drop_m[k] && w_addr == 5'd0)) begin
        we_m[k]   = 1'b1;
        addr_m[k] = w_addr;
        data_m[k] = w_data;
        if (k == 0) rf_m[w_addr] = w_data;
      end
    end
    if (b_fav_m[k]) begin
      wait_m[k] = 0;
      if (ba || !b_valid) b_fav_m[k] = 1'b0;
    end else if (b_valid && !ba) begin
      wait_m[k] = (wait_m[k] < 15) ? wait_m[k] + 1 : 15;
      if (wait_m[k] == lim_m[k]) begin
        b_fav_m[k] = 1'b1;
        wait_m[k]  = 0;
      end
    end else begin
      wait_m[k] = 0;
    end
  endtask

  initial begin : model
    for (int i = 0; i < 32; i++) begin
      rf_m[i]   = 32'd0;
      rf_dut[i] = 32'd0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          wait_m[k]  = 0;
          b_fav_m[k] = 1'b0;
          we_m[k]    = 1'b0;
          addr_m[k]  = 5'd0;
          data_m[k]  = 32'd0;
        end
      end else begin
        for (int k = 0; k < 2; k++) step_m(k);
      end
    end
  end

  task automatic cmp_inst(input int k, input logic ar, input logic br, input logic we,
                          input logic [4:0] ad, input logic [31:0] d, input logic st);
    bit ear, ebr;
    ready_m(k, ear, ebr);
    chk($sformatf("i%0d a_ready", k), 32'(ar), 32'(ear));
    chk($sformatf("i%0d b_ready", k), 32'(br), 32'(ebr));
    chk($sformatf("i%0d RegWrite", k), 32'(we), 32'(we_m[k]));
    chk($sformatf("i%0d RDaddr", k), 32'(ad), 32'(addr_m[k]));
    chk($sformatf("i%0d RDdata", k), d, data_m[k]);
    chk($sformatf("i%0d b_starved", k), 32'(st), 32'(b_fav_m[k]));
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      cmp_inst(0, if0.a_ready_o, if0.b_ready_o, if0.RegWrite_o, if0.RDaddr_o, if0.RDdata_o, if0.b_starved_o);
      cmp_inst(1, if1.a_ready_o, if1.b_ready_o, if1.RegWrite_o, if1.RDaddr_o, if1.RDdata_o, if1.b_starved_o);
      if (if0.RegWrite_o) rf_dut[if0.RDaddr_o] = if0.RDdata_o;
    end
  end

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    #3;
    chk("rst RegWrite", 32'(if0.RegWrite_o), 0);
    chk("rst RDaddr", 32'(if0.RDaddr_o), 0);
    chk("rst RDdata", if0.RDdata_o, 0);
    chk("rst b_starved", 32'(if0.b_starved_o), 0);
    nxt(); nxt();
    rst = 1'b0;
    nxt();

    // A alone
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0); #1;
    chk("a_only a_ready", 32'(if0.a_ready_o), 1);
    nxt(); idle(); #1;
    chk("a_only we", 32'(if0.RegWrite_o), 1);
    chk("a_only addr", 32'(if0.RDaddr_o), 5);
    chk("a_only data", if0.RDdata_o, 32'h1234);
    nxt(); #1;
    chk("a_only we_off", 32'(if0.RegWrite_o), 0);
    chk("a_only addr_hold", 32'(if0.RDaddr_o), 5);

    // starvation with A streaming
    for (int c = 0; c < 3; c++) begin
      if (c > 0) nxt();
      drive(1'b1, 5'd1, 32'hA0 + 32'(c), 1'b1, 5'd7, 32'hBEEF); #1;
      chk($sformatf("starve c%0d b_ready", c), 32'(if0.b_ready_o), 0);
      chk($sformatf("starve c%0d b_starved", c), 32'(if0.b_starved_o), 0);
    end
    nxt(); drive(1'b1, 5'd1, 32'hA3, 1'b1, 5'd7, 32'hBEEF); #1;
    chk("starve c3 b_starved", 32'(if0.b_starved_o), 1);
    chk("starve c3 b_ready", 32'(if0.b_ready_o), 1);
    chk("starve c3 a_ready", 32'(if0.a_ready_o), 0);
    nxt(); drive(1'b1, 5'd1, 32'hA4, 1'b0, 5'd0, 32'd0); #1;
    chk("starve c4 we", 32'(if0.RegWrite_o), 1);
    chk("starve c4 addr", 32'(if0.RDaddr_o), 7);
    chk("starve c4 data", if0.RDdata_o, 32'hBEEF);
    chk("starve c4 b_starved", 32'(if0.b_starved_o), 0);
    chk("starve c4 a_ready", 32'(if0.a_ready_o), 1);
    nxt(); idle();
    nxt();

    // B withdraws while forced, then the wait count starts from zero again
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd2, 32'h20 + 32'(c), 1'b1, 5'd9, 32'h99);
      nxt();
    end
    drive(1'b1, 5'd2, 32'h23, 1'b0, 5'd0, 32'd0); #1;
    chk("withdraw c3 b_starved", 32'(if0.b_starved_o), 1);
    chk("withdraw c3 a_ready", 32'(if0.a_ready_o), 1);
    nxt(); drive(1'b1, 5'd2, 32'h24, 1'b1, 5'd9, 32'h99); #1;
    chk("withdraw c4 b_starved", 32'(if0.b_starved_o), 0);
    chk("withdraw c4 addr", 32'(if0.RDaddr_o), 2);
    chk("withdraw c4 data", if0.RDdata_o, 32'h23);
    for (int c = 5; c < 8; c++) begin
      nxt(); drive(1'b1, 5'd2, 32'h20 + 32'(c), 1'b1, 5'd9, 32'h99); #1;
      if (c == 6) chk("withdraw c6 b_starved", 32'(if0.b_starved_o), 0);
      if (c == 7) chk("withdraw c7 b_starved", 32'(if0.b_starved_o), 1);
    end
    nxt(); idle(); #1;
    chk("withdraw c8 addr", 32'(if0.RDaddr_o), 9);
    chk("withdraw c8 data", if0.RDdata_o, 32'h99);
    nxt();

    // r0 write: dropped by instance 0, kept by instance 1
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF); #1;
    chk("r0 b_ready i0", 32'(if0.b_ready_o), 1);
    chk("r0 b_ready i1", 32'(if1.b_ready_o), 1);
    nxt(); idle(); #1;
    chk("r0 we i0", 32'(if0.RegWrite_o), 0);
    chk("r0 addr_hold i0", 32'(if0.RDaddr_o), 9);
    chk("r0 we i1", 32'(if1.RegWrite_o), 1);
    chk("r0 addr i1", 32'(if1.RDaddr_o), 0);
    chk("r0 data i1", if1.RDdata_o, 32'hFFFF_FFFF);
    nxt();

    // same-address collision
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22); #1;
    chk("coll c0 a_ready", 32'(if0.a_ready_o), 1);
    chk("coll c0 b_ready", 32'(if0.b_ready_o), 0);
    nxt(); drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h22); #1;
    chk("coll c1 data", if0.RDdata_o, 32'h11);
    chk("coll c1 b_ready", 32'(if0.b_ready_o), 1);
    nxt(); idle(); #1;
    chk("coll c2 we", 32'(if0.RegWrite_o), 1);
    chk("coll c2 addr", 32'(if0.RDaddr_o), 3);
    chk("coll c2 data", if0.RDdata_o, 32'h22);
    nxt(); #1;
    chk("coll rf_dut[3]", rf_dut[3], 32'h22);
    chk("coll rf_m[3]", rf_m[3], 32'h22);

    // async reset while a write is on the port
    drive(1'b1, 5'd12, 32'h5A5A, 1'b0, 5'd0, 32'd0); #1;
    chk("arst a_ready", 32'(if0.a_ready_o), 1);
    nxt(); idle(); #1;
    chk("arst we_before", 32'(if0.RegWrite_o), 1);
    #1 rst = 1'b1; #1;
    chk("arst we", 32'(if0.RegWrite_o), 0);
    chk("arst addr", 32'(if0.RDaddr_o), 0);
    chk("arst data", if0.RDdata_o, 0);
    nxt(); rst = 1'b0;
    nxt(); #1;
    chk("arst post_release we", 32'(if0.RegWrite_o), 0);

    // async reset in FORCE_B with the forced B transfer accepted but unwritten
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd4, 32'h40 + 32'(c), 1'b1, 5'd8, 32'h88);
      nxt();
    end
    #1;
    chk("arst2 b_starved", 32'(if0.b_starved_o), 1);
    #1 rst = 1'b1; idle(); #1;
    chk("arst2 b_starved_clr", 32'(if0.b_starved_o), 0);
    nxt(); rst = 1'b0;
    nxt(); #1;
    chk("arst2 post_release we", 32'(if0.RegWrite_o), 0);
    chk("arst2 post_release addr", 32'(if0.RDaddr_o), 0);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive cycles requester B may be held off before it is forced a grant; legal range 1..15.
REQ-002 Parameter DROP_R0, default 1: when 1, accepted writes to address 0 are consumed and never reach the register file.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset; asynchronous, active-high.
REQ-005 a_valid_i  input  1  requester A (pipeline writeback) has a write pending.
REQ-006 a_addr_i  input  5  requester A destination register.
REQ-007 a_data_i  input  32  requester A write data.
REQ-008 a_ready_o  output  1  requester A write accepted this cycle when high together with a_valid_i.
REQ-009 b_valid_i  input  1  requester B (multi-cycle unit) has a write pending.
REQ-010 b_addr_i  input  5  requester B destination register.
REQ-011 b_data_i  input  32  requester B write data.
REQ-012 b_ready_o  output  1  requester B write accepted this cycle when high together with b_valid_i.
REQ-013 RegWrite_o  output  1  write enable to the register file write port.
REQ-014 RDaddr_o  output  5  write address to the register file.
REQ-015 RDdata_o  output  32  write data to the register file.
REQ-016 b_starved_o  output  1  high while the arbiter is in state FORCE_B.

Function
REQ-017 The arbiter SHALL have two states: NORM (A has priority) and FORCE_B (B has priority).
REQ-018 In NORM: a_ready_o = 1; b_ready_o = b_valid_i and not a_valid_i.
REQ-019 In FORCE_B: b_ready_o = 1; a_ready_o = not b_valid_i.
REQ-020 Ready outputs SHALL be combinational from state and valids only; they SHALL never depend on data or address inputs.
REQ-021 At most one transfer SHALL be accepted per cycle; a_ready_o and b_ready_o SHALL never both be high while both valids are high.
REQ-022 Wait counter (4 bits): in NORM, increments when b_valid_i=1 and B is not accepted; clears when B is accepted or b_valid_i=0; saturates at 15.
REQ-023 NORM -> FORCE_B at the clock edge where the counter would reach STARVE_LIMIT; the counter clears on that transition.
REQ-024 FORCE_B -> NORM on the edge where B is accepted, or where b_valid_i=0 (B withdrew); there is no other exit.
REQ-025 An accepted transfer SHALL appear on RegWrite_o/RDaddr_o/RDdata_o exactly one cycle later (registered output, latency 1), held for exactly one cycle.
REQ-026 With no accepted transfer in a cycle, RegWrite_o SHALL be 0 the next cycle; RDaddr_o/RDdata_o SHALL hold their last values.
REQ-027 With DROP_R0=1, an accepted transfer to address 0 SHALL assert ready normally but produce RegWrite_o=0 next cycle; it counts as a B acceptance for REQ-022/REQ-024.
REQ-028 Both requesters targeting the same address in one cycle SHALL be arbitrated as usual; the loser retries later and its write lands after the winner's (last-accepted value wins).
REQ-029 A requester holding valid without ready SHALL keep its address/data stable; the arbiter samples them only in the accepting cycle.

Reset
REQ-030 While rst_i=1, independently of clk_i: state=NORM, counter=0, RegWrite_o=0, RDaddr_o=0, RDdata_o=0, b_starved_o=0.
REQ-031 Reset asserted mid-operation SHALL discard any accepted-but-unwritten transfer; no write SHALL issue on the first edge after rst_i deasserts.

Verification
REQ-032 A only: a_valid_i=1, a_addr_i=5, a_data_i=0x1234 for one cycle -> a_ready_o=1; next cycle RegWrite_o=1, RDaddr_o=5, RDdata_o=0x1234; following cycle RegWrite_o=0.
REQ-033 Starvation, STARVE_LIMIT=3: a_valid_i=1 continuously, b_valid_i=1 (addr 7, data 0xBEEF) from cycle 0 -> b_ready_o=0 cycles 0-2, FORCE_B from cycle 3 with b_ready_o=1 and a_ready_o=0; RDaddr_o=7, RDdata_o=0xBEEF at cycle 4; NORM again at cycle 4.
REQ-034 B withdraws in FORCE_B: enter FORCE_B, then drop b_valid_i -> return to NORM next edge, a_ready_o=1, counter=0, no B write issued.
REQ-035 R0 drop: B alone writes addr 0, data 0xFFFF_FFFF -> b_ready_o=1; RegWrite_o stays 0; repeat with DROP_R0=0 -> RegWrite_o=1, RDaddr_o=0.
REQ-036 Same-address collision: A(addr 3, 0x11) and B(addr 3, 0x22) both valid, NORM -> write 0x11 at cycle 1, 0x22 at cycle 2 once A drops valid; final write to addr 3 is 0x22.
REQ-037 Async reset: accept A write, assert rst_i mid-cycle before the next edge -> RegWrite_o=0 immediately, state NORM; after release, no write on the first edge.
